rob_request_queue: RTL and testbench

- Request order buffer (ROB) that sits directly upstream of the SDRAM command generator.
- Accepts host read/write requests over a valid/ready handshake and packs each one into a fixed-format item.
- Items are stored in order in a circular buffer and presented first-word-fall-through to the command generator, which pops them with a one-cycle read strobe.
- Provides the empty, full and read-data signals that the command generator consumes.

---
 rtl/rob_request_queue.sv | 115 +++++++++++
 tb/tb_rob_request_queue.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rob_request_queue.sv
// rob_request_queue: in-order request buffer in front of the SDRAM command
// generator. Host requests are accepted on a valid/ready handshake and packed
// as {wr, bank, row, col, dqm, data}. Items are stored in a circular buffer
// and shown first-word-fall-through, one item popped per iROB_Rd strobe.
// Optional feature: define ROB_ALMOST_FULL_EN to add parameter AF_LEVEL and
// output oROB_AlmostFull (count >= AF_LEVEL).
`ifndef ROB_ITEM_W
`define ROB_ITEM_W 58
`endif

module rob_request_queue #(
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3,
  parameter int ROW_W  = 11,
  parameter int COL_W  = 8,
  parameter int ITEM_W = `ROB_ITEM_W
`ifdef ROB_ALMOST_FULL_EN
  ,
  parameter int AF_LEVEL = DEPTH - 2
`endif
) (
  input  logic              sclk,
  input  logic              sreset,
  input  logic              iFlush,
  input  logic              iReq_Valid,
  output logic              oReq_Ready,
  input  logic              iReq_Wr,
  input  logic [1:0]        iReq_Bank,
  input  logic [ROW_W-1:0]  iReq_Row,
  input  logic [COL_W-1:0]  iReq_Col,
  input  logic [3:0]        iReq_Dqm,
  input  logic [31:0]       iReq_Data,
  input  logic              iROB_Rd,
  output logic [ITEM_W-1:0] oROB_RdData,
  output logic              oROB_Empty,
  output logic              oROB_Full,
  output logic [PTR_W:0]    oROB_Count,
`ifdef ROB_ALMOST_FULL_EN
  output logic              oROB_AlmostFull,
`endif
  output logic              oOverflow,
  output logic              oUnderflow
);

  logic [ITEM_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              push, pop;
  logic [ITEM_W-1:0] item;

  // Status flags decoded from the registered count only
  always_comb begin
    oROB_Empty  = (count_q == '0);
    oROB_Full   = (count_q == (PTR_W+1)'(DEPTH));
    oReq_Ready  = ~oROB_Full;
    oROB_Count  = count_q;
    oOverflow   = overflow_q;
    oUnderflow  = underflow_q;
    oROB_RdData = mem_q[rptr_q];
`ifdef ROB_ALMOST_FULL_EN
    oROB_AlmostFull = (count_q >= (PTR_W+1)'(AF_LEVEL));
`endif
  end

  // Handshake decode, item packing and next-state for pointers, count, flags
  always_comb begin
    push = iReq_Valid & ~oROB_Full;
    pop  = iROB_Rd & ~oROB_Empty;
    item = {iReq_Wr, iReq_Bank, iReq_Row, iReq_Col,
            iReq_Wr ? iReq_Dqm : 4'h0, iReq_Wr ? iReq_Data : 32'h0};

    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q | (iReq_Valid & oROB_Full);
    underflow_d = underflow_q | (iROB_Rd & oROB_Empty);

    if (iFlush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  // Pointer, count and sticky-flag registers with synchronous reset
  always_ff @(posedge sclk) begin
    if (sreset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Item storage; contents survive reset and flush, only pointers are cleared
  always_ff @(posedge sclk) begin
    if (!sreset && !iFlush && push) mem_q[wptr_q] <= item;
  end

endmodule

// File: tb/tb_rob_request_queue.sv
// Testbench for rob_request_queue: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_rob_request_queue;
  localparam int DEPTH = 8;

  logic        sclk = 1'b0;
  logic        sreset, iFlush, iReq_Valid, iReq_Wr, iROB_Rd;
  logic [1:0]  iReq_Bank;
  logic [10:0] iReq_Row;
  logic [7:0]  iReq_Col;
  logic [3:0]  iReq_Dqm;
  logic [31:0] iReq_Data;
  logic        oReq_Ready, oROB_Empty, oROB_Full, oOverflow, oUnderflow;
  logic [57:0] oROB_RdData;
  logic [3:0]  oROB_Count;
`ifdef ROB_ALMOST_FULL_EN
  logic        oROB_AlmostFull;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [57:0] mq[$];
  logic        m_ov, m_un;

  always #5 sclk = ~sclk;

  rob_request_queue #(.DEPTH(DEPTH), .PTR_W(3), .ROW_W(11), .COL_W(8), .ITEM_W(58)) dut (
    .sclk(sclk), .sreset(sreset), .iFlush(iFlush),
    .iReq_Valid(iReq_Valid), .oReq_Ready(oReq_Ready), .iReq_Wr(iReq_Wr),
    .iReq_Bank(iReq_Bank), .iReq_Row(iReq_Row), .iReq_Col(iReq_Col),
    .iReq_Dqm(iReq_Dqm), .iReq_Data(iReq_Data), .iROB_Rd(iROB_Rd),
    .oROB_RdData(oROB_RdData), .oROB_Empty(oROB_Empty), .oROB_Full(oROB_Full),
    .oROB_Count(oROB_Count),
`ifdef ROB_ALMOST_FULL_EN
    .oROB_AlmostFull(oROB_AlmostFull),
`endif
    .oOverflow(oOverflow), .oUnderflow(oUnderflow)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [57:0] pack(input logic wr, input logic [1:0] bank,
                                       input logic [10:0] row, input logic [7:0] col,
                                       input logic [3:0] dqm, input logic [31:0] data);
    return {wr, bank, row, col, wr ? dqm : 4'h0, wr ? data : 32'h0};
  endfunction

  task automatic model_update();
    int unsigned sz;
    logic do_push, do_pop;
    sz = mq.size();
    if (sreset) begin
      mq.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      do_push = iReq_Valid && (sz < DEPTH);
      do_pop  = iROB_Rd && (sz > 0);
      if (iReq_Valid && sz == DEPTH) m_ov = 1'b1;
      if (iROB_Rd && sz == 0) m_un = 1'b1;
      if (iFlush) mq.delete();
      else begin
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(pack(iReq_Wr, iReq_Bank, iReq_Row, iReq_Col, iReq_Dqm, iReq_Data));
      end
    end
  endtask

  task automatic compare();
    int unsigned sz;
    sz = mq.size();
    check("empty", 64'(oROB_Empty), 64'(sz == 0));
    check("full",  64'(oROB_Full),  64'(sz == DEPTH));
    check("ready", 64'(oReq_Ready), 64'(sz != DEPTH));
    check("count", 64'(oROB_Count), 64'(sz));
    check("overflow",  64'(oOverflow),  64'(m_ov));
    check("underflow", 64'(oUnderflow), 64'(m_un));
    if (sz != 0) check("rddata", 64'(oROB_RdData), 64'(mq[0]));
`ifdef ROB_ALMOST_FULL_EN
    check("almost_full", 64'(oROB_AlmostFull), 64'(sz >= DEPTH - 2));
`endif
  endtask

  task automatic step();
    @(posedge sclk);
    model_update();
    #1;
    compare();
  endtask

  task automatic idle();
    sreset = 0; iFlush = 0; iReq_Valid = 0; iROB_Rd = 0;
  endtask

  task automatic rand_req();
    iReq_Wr   = 1'($urandom);
    iReq_Bank = 2'($urandom);
    iReq_Row  = 11'($urandom);
    iReq_Col  = 8'($urandom);
    iReq_Dqm  = 4'($urandom);
    iReq_Data = $urandom;
  endtask

  initial begin
    m_ov = 0; m_un = 0;
    idle(); rand_req();

    // reset then idle
    sreset = 1; step();
    idle();
    repeat (3) step();
    check("reset_count", 64'(oROB_Count), 64'd0);
    check("reset_empty", 64'(oROB_Empty), 64'd1);

    // single write push / pop
    iReq_Valid = 1; iReq_Wr = 1; iReq_Bank = 2; iReq_Row = 11'h155;
    iReq_Col = 8'h3C; iReq_Dqm = 4'h0; iReq_Data = 32'hDEADBEEF;
    step();
    idle();
    check("single_item", 64'(oROB_RdData), 64'({1'b1, 2'd2, 11'h155, 8'h3C, 4'h0, 32'hDEADBEEF}));
    check("single_wrbit", 64'(oROB_RdData[57]), 64'd1);
    check("single_count", 64'(oROB_Count), 64'd1);
    iROB_Rd = 1; step();
    idle();
    check("single_popped", 64'(oROB_Empty), 64'd1);

    // fill, overflow, drain in order
    for (int i = 0; i < DEPTH; i++) begin
      rand_req(); iReq_Valid = 1; step();
    end
    check("fill_full", 64'(oROB_Full), 64'd1);
    check("fill_ready", 64'(oReq_Ready), 64'd0);
    rand_req(); step();
    idle();
    check("ovf_flag", 64'(oOverflow), 64'd1);
    check("ovf_count", 64'(oROB_Count), 64'd8);
    iROB_Rd = 1;
    for (int i = 0; i < DEPTH; i++) step();
    idle();
    check("drain_empty", 64'(oROB_Empty), 64'd1);

    // steady state at count 4 with simultaneous push/pop across wrap
    sreset = 1; step(); idle();
    for (int i = 0; i < 4; i++) begin
      rand_req(); iReq_Valid = 1; step();
    end
    iROB_Rd = 1;
    for (int i = 0; i < 10; i++) begin
      rand_req(); step();
      check("steady_count", 64'(oROB_Count), 64'd4);
    end
    idle();
    iROB_Rd = 1;
    for (int i = 0; i < 4; i++) step();
    idle();

    // underflow is sticky through flush, cleared by reset
    iROB_Rd = 1; step(); idle();
    check("unf_flag", 64'(oUnderflow), 64'd1);
    check("unf_count", 64'(oROB_Count), 64'd0);
    iFlush = 1; step(); idle();
    check("unf_after_flush", 64'(oUnderflow), 64'd1);
    sreset = 1; step(); idle();
    check("unf_after_reset", 64'(oUnderflow), 64'd0);

    // flush wins over a simultaneous push
    for (int i = 0; i < 5; i++) begin
      rand_req(); iReq_Valid = 1; step();
    end
    iFlush = 1; rand_req(); step(); idle();
    check("flush_count", 64'(oROB_Count), 64'd0);
    check("flush_empty", 64'(oROB_Empty), 64'd1);

`ifdef ROB_ALMOST_FULL_EN
    for (int i = 0; i < 6; i++) begin
      rand_req(); iReq_Valid = 1; step();
    end
    idle();
    check("af_set", 64'(oROB_AlmostFull), 64'd1);
    iROB_Rd = 1; step(); idle();
    check("af_clear", 64'(oROB_AlmostFull), 64'd0);
    iFlush = 1; step(); idle();
`endif

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      idle(); rand_req();
      r = $urandom_range(0, 99);
      if (r == 0) sreset = 1;
      else if (r < 3) iFlush = 1;
      else begin
        iReq_Valid = ($urandom_range(0, 99) < 55);
        iROB_Rd    = ($urandom_range(0, 99) < 50);
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
